wb_arb_watchdog: RTL
====================

// Module: wb_arb_watchdog
// PURPOSE
//  Two-requester Wishbone pipelined-mode arbiter with a per-grant transaction
//  watchdog. It sits between the AXI-lite read/write bridge halves (A = read
//  side, B = write side) and the downstream WB slave (I2C core). It grants the
//  bus, tracks outstanding requests, and aborts a hung transaction with an
//  error to the owning requester.
// PARAMETERS
//  AW               28             WB word-address width
//  DW               8              WB data width; sel width = DW/8
//  SCHEME           "ALTERNATING"  "ALTERNATING" or "PRIORITY" (A wins ties)
//  TIMEOUT_CYCLES   10             idle-progress cycles before abort, 1..255
//  LGMAXPEND        4              log2 of outstanding-request counter depth
//  OPT_ZERO_ON_IDLE 1'b0           1: adr/dat/sel/we driven 0 while not owned
// PORTS
//  i_clk             in   1      system clock
//  i_axi_reset_n     in   1      reset, asynchronous, active-low
//  i_{a,b}_cyc/stb/we in  1 each requester cycle, strobe, write enable
//  i_{a,b}_adr       in   AW     requester address
//  i_{a,b}_dat       in   DW     requester write data
//  i_{a,b}_sel       in   DW/8   requester byte select
//  o_{a,b}_stall     out  1      stall back to requester
//  o_{a,b}_ack       out  1      ack back to requester
//  o_{a,b}_err       out  1      error back to requester (slave err or timeout)
//  o_cyc/o_stb/o_we  out  1 each arbitrated WB master controls
//  o_adr/o_dat/o_sel out  AW/DW/DW/8  arbitrated WB master address/data/select
//  i_stall/i_ack/i_err in 1 each downstream slave responses
//  o_owner           out  2      one-hot current grant {B,A}; 0 = none
//  o_timeout         out  1      one-cycle pulse when an abort fires
// BEHAVIOUR
//  - FSM (registered): IDLE, OWN_A, OWN_B, ABORT. Reset: IDLE, o_cyc=o_stb=0,
//    o_owner=0, o_timeout=0, acks/errs 0, both stalls 1, counters 0,
//    last-served = B (so A wins the first tie).
//  - IDLE: requester with cyc high is granted next edge. Both high: PRIORITY
//    grants A; ALTERNATING grants the one not last served. Grant latency 1 clk.
//  - OWN_x: owner's cyc/stb/we/adr/dat/sel pass combinationally to o_*;
//    owner sees i_stall/i_ack/i_err. Non-owner: stall=1, ack=0, err=0.
//    Owner drops cyc: next state chosen as from IDLE on the same edge
//    (zero-gap handoff); pending counter cleared.
//  - Pending count: +1 on o_stb&!i_stall; -1 on i_ack; both at once: no change.
//    At max (2^LGMAXPEND-1): owner stall forced 1, o_stb gated 0.
//    i_ack with pending==0 is dropped, not forwarded.
//  - i_err while owned: forwarded to owner, pending cleared, state held until
//    owner drops cyc.
//  - Watchdog: 8-bit count, cleared on grant, i_ack, i_err or accepted stb.
//    Increments while owner cyc high and (pending>0 or o_stb stalled).
//    Reaching TIMEOUT_CYCLES: enter ABORT.
//  - ABORT: o_cyc=o_stb=0; owner err=1 for the first ABORT cycle only;
//    o_timeout=1 that cycle; pending cleared; owner stall=1. Stays until owner
//    cyc low, then arbitrates as IDLE. Late i_ack/i_err in ABORT are ignored.
//  - o_adr/o_dat/o_sel/o_we with no owner: 0 if OPT_ZERO_ON_IDLE, else requester
//    A's values.
//  - Reset asserted mid-transaction: all state cleared asynchronously, outputs
//    take reset values immediately.
// STRUCTURE
//  - wb_arb_pkg: state enum (IDLE/OWN_A/OWN_B/ABORT), SCHEME string constants,
//    owner one-hot encodings.
//  - Sub-module wb_watchdog_cnt: clear/enable inputs, saturating counter,
//    expiry flag at TIMEOUT_CYCLES. Arbiter FSM and muxes stay top-level.
// TESTING
//  1 A read: a_cyc/stb, slave ack 2 clk after accept -> o_owner=01 after
//    1 clk, a_ack once, pending back to 0, b_stall stays 1.
//  2 A and B cyc same cycle, ALTERNATING, 4 back-to-back txns -> grants
//    A,B,A,B; PRIORITY -> A until a_cyc drops.
//  3 Slave never acks, TIMEOUT_CYCLES=10 -> o_timeout pulse 10 clk after the
//    accepted stb; o_cyc low; a_err exactly 1 clk; late i_ack not forwarded.
//  4 LGMAXPEND=2, slave stalls acks -> 3 stbs accepted, 4th held (a_stall=1)
//    until an ack arrives.
//  5 i_err mid-burst on B -> b_err 1 clk, pending 0, next grant after b_cyc low.
//  6 Reset pulled low during OWN_B with pending=2 -> o_cyc=0, o_owner=0 same
//    cycle; after release, fresh A request granted in 1 clk.

Source files
------------

// File: rtl/wb_arb_watchdog_pkg.sv
// Shared types for the two-requester Wishbone arbiter with a transaction watchdog.
//   arb_state_e : arbiter FSM states
//   SCHEME_*    : recognised arbitration scheme names
//   OWNER_*     : one-hot grant encodings {B,A}
//   arb_pick    : tie-break helper used from IDLE and on zero-gap handoff
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN_A,
    ST_OWN_B,
    ST_ABORT
  } arb_state_e;

  localparam string SCHEME_ALT = "ALTERNATING";
  localparam string SCHEME_PRI = "PRIORITY";

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  // On a tie: priority mode always picks A, alternating picks whoever was not served last.
  function automatic logic [1:0] arb_pick(input logic a_req, input logic b_req,
                                          input logic last_b, input logic pri);
    if (a_req && b_req) return (pri || last_b) ? OWNER_A : OWNER_B;
    if (a_req)          return OWNER_A;
    if (b_req)          return OWNER_B;
    return OWNER_NONE;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog_if.sv
// Bus bundle between the two requesters (A = read side, B = write side), the
// arbiter and the downstream Wishbone slave.
//   i_{a,b}_*  : requester cyc/stb/we/adr/dat/sel
//   o_{a,b}_*  : stall/ack/err returned to each requester
//   o_*        : arbitrated Wishbone master signals
//   i_stall/i_ack/i_err : downstream slave responses
// Modport master = the arbiter; modport slave = the surrounding environment.
interface wb_arb_watchdog_if #(
  parameter int AW = 28,
  parameter int DW = 8
);
  localparam int SW = DW / 8;

  logic          i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0] i_a_adr;
  logic [DW-1:0] i_a_dat;
  logic [SW-1:0] i_a_sel;
  logic          o_a_stall, o_a_ack, o_a_err;

  logic          i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0] i_b_adr;
  logic [DW-1:0] i_b_dat;
  logic [SW-1:0] i_b_sel;
  logic          o_b_stall, o_b_ack, o_b_err;

  logic          o_cyc, o_stb, o_we;
  logic [AW-1:0] o_adr;
  logic [DW-1:0] o_dat;
  logic [SW-1:0] o_sel;
  logic          i_stall, i_ack, i_err;

  modport master (
    input  i_a_cyc, i_a_stb, i_a_we, i_a_adr, i_a_dat, i_a_sel,
    output o_a_stall, o_a_ack, o_a_err,
    input  i_b_cyc, i_b_stb, i_b_we, i_b_adr, i_b_dat, i_b_sel,
    output o_b_stall, o_b_ack, o_b_err,
    output o_cyc, o_stb, o_we, o_adr, o_dat, o_sel,
    input  i_stall, i_ack, i_err
  );

  modport slave (
    output i_a_cyc, i_a_stb, i_a_we, i_a_adr, i_a_dat, i_a_sel,
    input  o_a_stall, o_a_ack, o_a_err,
    output i_b_cyc, i_b_stb, i_b_we, i_b_adr, i_b_dat, i_b_sel,
    input  o_b_stall, o_b_ack, o_b_err,
    input  o_cyc, o_stb, o_we, o_adr, o_dat, o_sel,
    output i_stall, i_ack, i_err
  );

endinterface

// File: rtl/wb_arb_watchdog_cnt.sv
// Saturating 8-bit idle-progress counter for the arbiter watchdog.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : restart the count (has priority over i_en)
//   i_en           : count this cycle
//   o_hit          : the count reaches TIMEOUT_CYCLES on the coming edge
module wb_watchdog_cnt #(
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                      cnt_d = '0;
    else if (i_en && cnt_q != '1)   cnt_d = cnt_q + 8'd1;
  end

  // Flag one cycle early so the abort lands exactly TIMEOUT_CYCLES edges after the last progress.
  assign o_hit = i_en && !i_clr && (cnt_q == LIMIT_M1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_arb_watchdog.sv
// Two-requester Wishbone pipelined arbiter with per-grant transaction watchdog.
//   i_clk, i_axi_reset_n : clock, asynchronous active-low reset
//   bus                  : requester, master and slave signals (master modport)
//   o_owner              : one-hot current grant {B,A}, 0 = none
//   o_timeout            : one-cycle pulse when a hung transaction is aborted
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int    AW               = 28,
  parameter int    DW               = 8,
  parameter string SCHEME           = "ALTERNATING",
  parameter int    TIMEOUT_CYCLES   = 10,
  parameter int    LGMAXPEND        = 4,
  parameter bit    OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_axi_reset_n,
  wb_arb_watchdog_if.master   bus,
  output logic [1:0]          o_owner,
  output logic                o_timeout
);

  localparam int SW = DW / 8;
  localparam bit IS_PRI = (SCHEME != SCHEME_ALT) && (SCHEME == SCHEME_PRI);
  localparam logic [LGMAXPEND-1:0] PEND_MAX = '1;
  localparam logic [LGMAXPEND-1:0] PEND_ONE = LGMAXPEND'(1);

  arb_state_e           st_q, st_d;
  logic [1:0]           owner_q, owner_d;
  logic                 last_b_q, last_b_d;
  logic [LGMAXPEND-1:0] pend_q, pend_d;
  logic                 tmo_q, tmo_d;
  logic                 aerr_q, aerr_d;

  logic       owning, ow_cyc, ow_stb, ow_we;
  logic       pend_nz, pend_full, accept;
  logic       ow_stall, ow_ack, ow_err;
  logic       wd_clr, wd_en, wd_hit;
  logic [1:0] grant;

  logic [AW-1:0] idle_adr;
  logic [DW-1:0] idle_dat;
  logic [SW-1:0] idle_sel;
  logic          idle_we;

  // owner_q also stays valid in ABORT so the error and release go to the right requester.
  assign owning = (st_q == ST_OWN_A) || (st_q == ST_OWN_B);
  assign ow_cyc = owner_q[1] ? bus.i_b_cyc : bus.i_a_cyc;
  assign ow_stb = owner_q[1] ? bus.i_b_stb : bus.i_a_stb;
  assign ow_we  = owner_q[1] ? bus.i_b_we  : bus.i_a_we;

  assign pend_nz   = (pend_q != '0);
  assign pend_full = (pend_q == PEND_MAX);

  assign bus.o_cyc = owning && ow_cyc;
  assign bus.o_stb = owning && ow_cyc && ow_stb && !pend_full;
  assign accept    = bus.o_stb && !bus.i_stall;

  assign idle_adr = OPT_ZERO_ON_IDLE ? '0   : bus.i_a_adr;
  assign idle_dat = OPT_ZERO_ON_IDLE ? '0   : bus.i_a_dat;
  assign idle_sel = OPT_ZERO_ON_IDLE ? '0   : bus.i_a_sel;
  assign idle_we  = OPT_ZERO_ON_IDLE ? 1'b0 : bus.i_a_we;

  assign bus.o_adr = owning ? (owner_q[1] ? bus.i_b_adr : bus.i_a_adr) : idle_adr;
  assign bus.o_dat = owning ? (owner_q[1] ? bus.i_b_dat : bus.i_a_dat) : idle_dat;
  assign bus.o_sel = owning ? (owner_q[1] ? bus.i_b_sel : bus.i_a_sel) : idle_sel;
  assign bus.o_we  = owning ? ow_we : idle_we;

  // Acks with nothing outstanding are stray and are swallowed.
  assign ow_stall = !owning || bus.i_stall || pend_full;
  assign ow_ack   = owning && bus.i_ack && pend_nz;
  assign ow_err   = owning ? bus.i_err : ((st_q == ST_ABORT) && aerr_q);

  assign bus.o_a_stall = owner_q[0] ? ow_stall : 1'b1;
  assign bus.o_a_ack   = owner_q[0] && ow_ack;
  assign bus.o_a_err   = owner_q[0] && ow_err;
  assign bus.o_b_stall = owner_q[1] ? ow_stall : 1'b1;
  assign bus.o_b_ack   = owner_q[1] && ow_ack;
  assign bus.o_b_err   = owner_q[1] && ow_err;

  assign grant = arb_pick(bus.i_a_cyc, bus.i_b_cyc, last_b_q, IS_PRI);

  assign wd_clr = !owning || !ow_cyc || bus.i_ack || bus.i_err || accept;
  assign wd_en  = owning && ow_cyc && (pend_nz || (ow_stb && ow_stall));

  wb_watchdog_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk  (i_clk),
    .i_rst_n(i_axi_reset_n),
    .i_clr  (wd_clr),
    .i_en   (wd_en),
    .o_hit  (wd_hit)
  );

  always_comb begin
    st_d     = st_q;
    owner_d  = owner_q;
    last_b_d = last_b_q;
    pend_d   = pend_q;
    tmo_d    = 1'b0;
    aerr_d   = 1'b0;
    // IDLE and owner release share one path, giving a zero-gap handoff from OWN_x and ABORT.
    if (st_q == ST_IDLE || !ow_cyc) begin
      pend_d  = '0;
      owner_d = grant;
      if (grant[0]) begin
        st_d     = ST_OWN_A;
        last_b_d = 1'b0;
      end else if (grant[1]) begin
        st_d     = ST_OWN_B;
        last_b_d = 1'b1;
      end else begin
        st_d = ST_IDLE;
      end
    end else if (st_q == ST_ABORT) begin
      pend_d = '0;
    end else if (wd_hit) begin
      st_d   = ST_ABORT;
      pend_d = '0;
      tmo_d  = 1'b1;
      aerr_d = 1'b1;
    end else if (bus.i_err) begin
      pend_d = '0;
    end else if (accept && !ow_ack) begin
      pend_d = pend_q + PEND_ONE;
    end else if (!accept && ow_ack) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      st_q     <= ST_IDLE;
      owner_q  <= OWNER_NONE;
      last_b_q <= 1'b1;
      pend_q   <= '0;
      tmo_q    <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      owner_q  <= owner_d;
      last_b_q <= last_b_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      aerr_q   <= aerr_d;
    end
  end

  assign o_owner   = owner_q;
  assign o_timeout = tmo_q;

endmodule
